// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Index width for n requesters; never below one bit.
   function automatic int ARB_IDX_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Requester/sink handshake bundle between the requesters and the burst arbiter.
interface rr_burst_arbiter_if #(
   parameter int N         = 4,
   parameter int MAX_BEATS = 16
);
   import arb_pkg::*;

   localparam int IDX_W = ARB_IDX_W(N);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   logic [N-1:0]     req;
   logic [N-1:0]     last;
   logic             ready_in;
   logic [N-1:0]     grant;
   logic [IDX_W-1:0] gnt_id;
   logic             busy;
   logic [CNT_W-1:0] beat_cnt;
   logic             forced_rel;

   modport master (
      output req, last, ready_in,
      input  grant, gnt_id, busy, beat_cnt, forced_rel
   );

   modport slave (
      input  req, last, ready_in,
      output grant, gnt_id, busy, beat_cnt, forced_rel
   );

endinterface

// File: rtl/rr_burst_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr wins.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]              req,
   input  logic [ARB_IDX_W(N)-1:0]   ptr,
   output logic [N-1:0]              pick,
   output logic [ARB_IDX_W(N)-1:0]   pick_id,
   output logic                      any
);
   localparam int IDX_W = ARB_IDX_W(N);

   logic [N-1:0] one_s;

   // Index ptr+off wrapped modulo N (N need not be a power of two).
   function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= N) begin
         sum = sum - N;
      end else begin
         sum = sum;
      end
      return IDX_W'(sum);
   endfunction

   assign one_s = N'(1'b1);

   // Scan from the lowest priority down so the highest-priority hit is written last.
   always_comb begin
      pick_id = '0;
      any     = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[rot(ptr, i)]) begin
            pick_id = rot(ptr, i);
         end else begin
            pick_id = pick_id;
         end
      end
      pick = any ? (one_s << pick_id) : '0;
   end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting a shared sink per burst, with a beat-count limit
// that forces release; all outputs registered.
module rr_burst_arbiter
   import arb_pkg::*;
#(
   parameter int N         = 4,
   parameter int MAX_BEATS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_burst_arbiter_if.slave bus
);
   localparam int IDX_W = ARB_IDX_W(N);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
   localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(N - 1);

   arb_state_e       state_r, state_s;
   logic [N-1:0]     grant_r, grant_s;
   logic [IDX_W-1:0] gnt_id_r, gnt_id_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [IDX_W-1:0] ptr_r, ptr_s;
   logic             frel_r, frel_s;
   logic             busy_r;

   logic [IDX_W-1:0] next_id_s;
   logic [IDX_W-1:0] arb_ptr_s;
   logic [N-1:0]     pick_s;
   logic [IDX_W-1:0] pick_id_s;
   logic             any_s;
   logic             beat_s, rel_last_s, rel_max_s, release_s;

   assign next_id_s  = (gnt_id_r == TOP_IDX) ? '0 : gnt_id_r + IDX_W'(1);
   // While busy, arbitration only matters on a release, where priority starts past g.
   assign arb_ptr_s  = (state_r == BUSY) ? next_id_s : ptr_r;
   assign beat_s     = (state_r == BUSY) & bus.req[gnt_id_r] & bus.ready_in;
   assign rel_last_s = beat_s & bus.last[gnt_id_r];
   assign rel_max_s  = beat_s & (cnt_r == LAST_CNT);
   assign release_s  = rel_last_s | rel_max_s;

   rr_pick #(.N(N)) u_pick (
      .req     (bus.req),
      .ptr     (arb_ptr_s),
      .pick    (pick_s),
      .pick_id (pick_id_s),
      .any     (any_s)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_s  = state_r;
      grant_s  = grant_r;
      gnt_id_s = gnt_id_r;
      cnt_s    = cnt_r;
      ptr_s    = ptr_r;
      frel_s   = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_s = '0;
            if (any_s) begin
               state_s  = BUSY;
               grant_s  = pick_s;
               gnt_id_s = pick_id_s;
            end else begin
               grant_s  = '0;
               gnt_id_s = '0;
            end
         end
         BUSY: begin
            if (release_s) begin
               ptr_s  = next_id_s;
               frel_s = rel_max_s & ~rel_last_s;
               cnt_s  = '0;
               if (any_s) begin
                  grant_s  = pick_s;
                  gnt_id_s = pick_id_s;
               end else begin
                  state_s  = IDLE;
                  grant_s  = '0;
                  gnt_id_s = '0;
               end
            end else if (beat_s) begin
               cnt_s = cnt_r + CNT_W'(1);
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s  = IDLE;
            grant_s  = '0;
            gnt_id_s = '0;
            cnt_s    = '0;
            ptr_s    = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         grant_r  <= '0;
         gnt_id_r <= '0;
         cnt_r    <= '0;
         ptr_r    <= '0;
         frel_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         grant_r  <= grant_s;
         gnt_id_r <= gnt_id_s;
         cnt_r    <= cnt_s;
         ptr_r    <= ptr_s;
         frel_r   <= frel_s;
         busy_r   <= (state_s == BUSY);
      end
   end

   assign bus.grant      = grant_r;
   assign bus.gnt_id     = gnt_id_r;
   assign bus.busy       = busy_r;
   assign bus.beat_cnt   = cnt_r;
   assign bus.forced_rel = frel_r;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter (N=4, MAX_BEATS=4) with a queued expectation scoreboard.
module tb_rr_burst_arbiter;

   typedef struct {
      string      tag;
      logic [3:0] grant;
      logic [1:0] id;
      logic       busy;
      logic [2:0] cnt;
      logic       frel;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   exp_t sb[$];

   rr_burst_arbiter_if #(.N(4), .MAX_BEATS(4)) bus ();

   rr_burst_arbiter #(.N(4), .MAX_BEATS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input exp_t e);
      chk({e.tag, ".grant"}, 32'(bus.grant), 32'(e.grant));
      chk({e.tag, ".gnt_id"}, 32'(bus.gnt_id), 32'(e.id));
      chk({e.tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
      chk({e.tag, ".beat_cnt"}, 32'(bus.beat_cnt), 32'(e.cnt));
      chk({e.tag, ".forced_rel"}, 32'(bus.forced_rel), 32'(e.frel));
   endtask

   function automatic exp_t mk(input string tag, input int g, input int cnt, input logic frel);
      exp_t e;
      e.tag   = tag;
      e.grant = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      e.id    = (g >= 0) ? 2'(g) : 2'd0;
      e.busy  = (g >= 0);
      e.cnt   = 3'(cnt);
      e.frel  = frel;
      return e;
   endfunction

   // One clock cycle: drive inputs, queue the expected post-edge outputs, compare.
   task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                      input int g, input int cnt, input logic frel, input string tag);
      exp_t e;
      bus.req      = r;
      bus.last     = l;
      bus.ready_in = rdy;
      sb.push_back(mk(tag, g, cnt, frel));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_all(e);
   endtask

   // Assert reset away from the edge, check outputs drop at once, then release.
   task automatic do_reset(input string tag);
      bus.req      = 4'b0000;
      bus.last     = 4'b0000;
      bus.ready_in = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_all(mk(tag, -1, 0, 1'b0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.req      = 4'b0000;
      bus.last     = 4'b0000;
      bus.ready_in = 1'b0;
      @(posedge clk);
      #1;

      // Alternating single-beat bursts between 0 and 2.
      do_reset("rst1");
      cyc(4'b0101, 4'b0101, 1'b1, 0, 0, 1'b0, "alt1");
      cyc(4'b0101, 4'b0101, 1'b1, 2, 0, 1'b0, "alt2");
      cyc(4'b0101, 4'b0101, 1'b1, 0, 0, 1'b0, "alt3");
      cyc(4'b0101, 4'b0101, 1'b1, 2, 0, 1'b0, "alt4");

      // Three-beat burst with ready_in toggling.
      do_reset("rst2");
      cyc(4'b0010, 4'b0000, 1'b1, 1, 0, 1'b0, "stall0");
      cyc(4'b0010, 4'b0000, 1'b1, 1, 1, 1'b0, "stall1");
      cyc(4'b0010, 4'b0000, 1'b0, 1, 1, 1'b0, "stall2");
      cyc(4'b0010, 4'b0000, 1'b1, 1, 2, 1'b0, "stall3");
      cyc(4'b0010, 4'b0000, 1'b0, 1, 2, 1'b0, "stall4");
      cyc(4'b0011, 4'b0010, 1'b1, 0, 0, 1'b0, "stall5");

      // Forced release after MAX_BEATS, then last+limit coinciding.
      do_reset("rst3");
      cyc(4'b1000, 4'b0000, 1'b1, 3, 0, 1'b0, "force0");
      cyc(4'b1000, 4'b0000, 1'b1, 3, 1, 1'b0, "force1");
      cyc(4'b1000, 4'b0000, 1'b1, 3, 2, 1'b0, "force2");
      cyc(4'b1000, 4'b0000, 1'b1, 3, 3, 1'b0, "force3");
      cyc(4'b1001, 4'b0000, 1'b1, 0, 0, 1'b1, "force4");
      cyc(4'b0001, 4'b0001, 1'b1, 0, 0, 1'b0, "force5");
      cyc(4'b0001, 4'b0000, 1'b1, 0, 1, 1'b0, "both1");
      cyc(4'b0001, 4'b0000, 1'b1, 0, 2, 1'b0, "both2");
      cyc(4'b0001, 4'b0000, 1'b1, 0, 3, 1'b0, "both3");
      cyc(4'b0001, 4'b0001, 1'b1, 0, 0, 1'b0, "both4");
      cyc(4'b0000, 4'b0000, 1'b1, 0, 0, 1'b0, "both5");

      // Owner drops req mid-burst; grant must be held.
      do_reset("rst4");
      cyc(4'b0100, 4'b0000, 1'b1, 2, 0, 1'b0, "hold0");
      cyc(4'b0101, 4'b0000, 1'b1, 2, 1, 1'b0, "hold1");
      cyc(4'b0001, 4'b0000, 1'b1, 2, 1, 1'b0, "hold2");
      cyc(4'b0001, 4'b0000, 1'b1, 2, 1, 1'b0, "hold3");
      cyc(4'b0001, 4'b0000, 1'b1, 2, 1, 1'b0, "hold4");
      cyc(4'b0101, 4'b0100, 1'b1, 0, 0, 1'b0, "hold5");

      // All four requesting single-beat bursts.
      do_reset("rst5");
      cyc(4'b1111, 4'b1111, 1'b1, 0, 0, 1'b0, "rr0");
      cyc(4'b1111, 4'b1111, 1'b1, 1, 0, 1'b0, "rr1");
      cyc(4'b1111, 4'b1111, 1'b1, 2, 0, 1'b0, "rr2");
      cyc(4'b1111, 4'b1111, 1'b1, 3, 0, 1'b0, "rr3");
      cyc(4'b1111, 4'b1111, 1'b1, 0, 0, 1'b0, "rr4");

      // Reset mid-burst on requester 2 with ptr at 3; pointer must return to 0.
      do_reset("rst6");
      cyc(4'b0100, 4'b0100, 1'b1, 2, 0, 1'b0, "mid0");
      cyc(4'b0100, 4'b0100, 1'b1, 2, 0, 1'b0, "mid1");
      cyc(4'b0100, 4'b0000, 1'b1, 2, 1, 1'b0, "mid2");
      do_reset("midrst");
      cyc(4'b1100, 4'b0000, 1'b1, 2, 0, 1'b0, "mid3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Round-robin arbiter that shares one downstream sink between N requesters at burst granularity: once a requester wins, it keeps the grant until its burst ends (`last` accepted) or a beat-count limit forces release. It sits between the requesters' valid/last lines and the shared datapath mux, driving a registered one-hot grant and index. A stall is expressed through `ready_in`; a burst is never split except by the forced-release limit.

## Interface
- `N`, 4, number of requesters (2..16)
- `MAX_BEATS`, 16, beats per grant before forced release (≥1)
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  N  per-requester valid; a beat is offered while high
- `last`  in  N  per-requester end-of-burst marker, qualified by `req`
- `ready_in`  in  1  downstream accepts the granted beat this cycle
- `grant`  out  N  one-hot registered grant, all-zero when idle
- `gnt_id`  out  $clog2(N)  index of granted requester, 0 when idle
- `busy`  out  1  high while a grant is held
- `beat_cnt`  out  $clog2(MAX_BEATS+1)  beats accepted in current grant
- `forced_rel`  out  1  one-cycle pulse: grant ended by MAX_BEATS, not `last`

## Operation
- States: IDLE (no grant), BUSY (grant held on requester g).
- Beat: cycle where BUSY and `req[g] & ready_in`. Nothing else advances `beat_cnt`.
- Release: beat with `last[g]`=1, or beat where `beat_cnt == MAX_BEATS-1`. Latter also pulses `forced_rel` next cycle. On a beat with both conditions true, `last` takes precedence (`forced_rel` stays 0).
- Arbitration: search starts at `ptr`, ascending mod N; first set `req` wins. `ptr` resets to 0; on every release `ptr <= g+1 mod N`, so the released requester has lowest priority.
- IDLE: any `req` set → register grant, go BUSY. No `req` → stay IDLE.
- BUSY, release cycle: arbitrate in the same cycle using updated priority (start at g+1); if any `req` set, load the new grant directly (back-to-back, no bubble; may be g again if it is the only requester); else go IDLE.
- BUSY, no release: grant held. `req[g]` dropping mid-burst does not release; the arbiter waits.
- `beat_cnt` clears to 0 on every new grant and in IDLE; increments per non-releasing beat.
- `ready_in` low: no beat, no state change, grant held.

## Timing
- Reset (async assert, sync-to-clk deassert by system): `grant`=0, `gnt_id`=0, `busy`=0, `beat_cnt`=0, `forced_rel`=0, `ptr`=0, state IDLE.
- Request-to-grant latency: 1 cycle (req sampled at edge k, `grant` valid after edge k+1). First beat can be accepted in the cycle grant is visible.
- Release-to-next-grant: 0 bubble cycles; new grant is visible the cycle after the releasing beat.
- All outputs registered; no combinational path from inputs to outputs.
- Reset mid-burst: grant drops immediately (async), pointer returns to 0.

## Structure
- Package `arb_pkg`: `arb_state_e` enum {IDLE, BUSY}; `ARB_IDX_W(n)` helper via `$clog2`.
- Sub-module `rr_pick`: combinational, params N; inputs `req`, `ptr`; outputs one-hot `pick`, index `pick_id`, `any`. Instantiated once; used by both IDLE and release-cycle arbitration.

## Test plan
- Reset then `req`=4'b0101, `last` on first beat, `ready_in`=1 → grants 0, then 2, then 0, alternating, each 1 cycle, no idle cycle between.
- Requester 1 burst of 3 beats with `ready_in` toggling 1,0,1,0,1 → `grant`=4'b0010 held 5 cycles, `beat_cnt` 0→1→1→2→2, released after 3rd beat.
- MAX_BEATS=4, requester 3 never asserts `last` → release after 4th beat, `forced_rel` pulses once, next grant goes to requester 0 if requesting.
- Requester 2 drops `req` mid-burst for 3 cycles with requester 0 requesting → grant stays 4'b0100; requester 0 not granted until requester 2 sends `last`.
- All 4 requesting, single-beat bursts → grant sequence 0,1,2,3,0 with `gnt_id` matching; `busy` constantly 1.
- Assert `rst_n`=0 mid-burst on requester 2 → `grant`=0 immediately; after release, with `req`=4'b1100, first grant is requester 2 (ptr=0).
